// File: rtl/mprf_pkg.sv
// Shared types and helpers for the multi-PE register file.
`define MPRF_FIELD(bus, idx, w) bus[(idx)*(w) +: (w)]

package mprf_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } mprf_state_e;

   // Ceiling log2, minimum 1 so a 2-entry file still gets a 1-bit address.
   function automatic int unsigned mprf_clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/mprf_write_arbiter.sv
// Same-address write arbitration: lowest-index PE wins, the rest are dropped.
module mprf_write_arbiter
   import mprf_pkg::*;
#(
   parameter int unsigned NUM_PE   = 2,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned AW       = mprf_clog2(DEPTH)
) (
   input  logic                 ready,
   input  logic [NUM_PE-1:0]    we,
   input  logic [NUM_PE*AW-1:0] waddr,
   output logic [NUM_PE-1:0]    winner_c,
   output logic [NUM_PE-1:0]    dropped_c
);

   logic [NUM_PE-1:0] valid_c;

   // Qualify each write, then let only the lowest valid PE per address through.
   always_comb begin
      valid_c   = '0;
      winner_c  = '0;
      dropped_c = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         valid_c[i] = ready && we[i]
                      && (32'(`MPRF_FIELD(waddr, i, AW)) < DEPTH)
                      && !((ZERO_REG != 0) && (`MPRF_FIELD(waddr, i, AW) == '0));
      end
      winner_c = valid_c;
      for (int i = 1; i < NUM_PE; i++) begin
         for (int j = 0; j < i; j++) begin
            if (valid_c[j] && (`MPRF_FIELD(waddr, j, AW) == `MPRF_FIELD(waddr, i, AW)))
               winner_c[i] = 1'b0;
         end
      end
      dropped_c = valid_c & ~winner_c;
   end

endmodule

// File: rtl/multi_pe_register_file.sv
// Register file shared by NUM_PE processing elements, with a clear sweeper.
module multi_pe_register_file
   import mprf_pkg::*;
#(
   parameter int unsigned NUM_PE   = 2,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 0,
   parameter int unsigned AW       = mprf_clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_PE-1:0]        we,
   input  logic [NUM_PE*AW-1:0]     waddr,
   input  logic [NUM_PE*DATA_W-1:0] wdata,
   input  logic [NUM_PE*AW-1:0]     raddr1,
   input  logic [NUM_PE*AW-1:0]     raddr2,
   output logic [NUM_PE*DATA_W-1:0] rdata1,
   output logic [NUM_PE*DATA_W-1:0] rdata2,
   input  logic                     clear_req,
   output logic                     busy,
   output logic [NUM_PE-1:0]        conflict
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   mprf_state_e       state;
   logic [AW-1:0]     clr_ptr;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              ready_c;
   logic [NUM_PE-1:0] winner_c;
   logic [NUM_PE-1:0] dropped_c;

   assign ready_c = (state == ST_READY);

   mprf_write_arbiter #(
      .NUM_PE   (NUM_PE),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_arb (
      .ready     (ready_c),
      .we        (we),
      .waddr     (waddr),
      .winner_c  (winner_c),
      .dropped_c (dropped_c)
   );

   // Clear sequencer, busy flag and conflict report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_CLEAR;
         clr_ptr  <= '0;
         busy     <= 1'b1;
         conflict <= '0;
      end else begin
         conflict <= dropped_c;
         case (state)
            ST_CLEAR: begin
               if (clr_ptr == LAST_IDX) begin
                  state   <= ST_READY;
                  busy    <= 1'b0;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + AW'(1);
               end
            end
            ST_READY: begin
               if (clear_req) begin
                  state   <= ST_CLEAR;
                  busy    <= 1'b1;
                  clr_ptr <= '0;
               end
            end
            default: begin
               state <= ST_CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage: sweep writes while clearing, arbitrated PE writes when ready.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR)
         regs[clr_ptr] <= '0;
      for (int p = 0; p < NUM_PE; p++) begin
         if (winner_c[p])
            regs[`MPRF_FIELD(waddr, p, AW)] <= `MPRF_FIELD(wdata, p, DATA_W);
      end
   end

   // One read port: bounds, hardwired zero, optional bypass, else stored value.
   function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
      if (ready_c && (32'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0))) begin
         val = regs[addr];
         if (BYPASS != 0) begin
            for (int p = 0; p < NUM_PE; p++) begin
               if (winner_c[p] && (`MPRF_FIELD(waddr, p, AW) == addr))
                  val = `MPRF_FIELD(wdata, p, DATA_W);
            end
         end
      end
      return val;
   endfunction

   // Combinational read muxing for both ports of every PE.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      for (int p = 0; p < NUM_PE; p++) begin
         `MPRF_FIELD(rdata1, p, DATA_W) = read_port(`MPRF_FIELD(raddr1, p, AW));
         `MPRF_FIELD(rdata2, p, DATA_W) = read_port(`MPRF_FIELD(raddr2, p, AW));
      end
   end

endmodule
